// File: rtl/fetch_unit_pf.sv
// Pipelined instruction fetch unit: issues sequential fetches under a credit limit,
// buffers in-order responses in a DEPTH-entry FIFO and flushes on redirect.
module fetch_unit_pf #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_base,
    input  logic [XLEN-1:0] redirect_offset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_link
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;

    logic [XLEN-1:0] mem_pc_q    [DEPTH];
    logic [XLEN-1:0] mem_instr_q [DEPTH];

    logic [CW:0]     credits_used;
    logic            credit_ok;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] target_sum;
    logic [XLEN-1:0] target;

    // Requests in flight plus buffered entries can never exceed the FIFO size,
    // so every response that is kept always has a free slot.
    assign credits_used = (CW + 1)'(inflight_q) + (CW + 1)'(count_q);
    assign credit_ok    = credits_used < (CW + 1)'(DEPTH);

    assign imem_req_valid = !reset && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_valid = count_q != '0;
    assign instr       = mem_instr_q[rd_ptr_q];
    assign instr_pc    = mem_pc_q[rd_ptr_q];
    assign instr_link  = instr_pc + XLEN'(4);

    assign push = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign pop  = instr_valid && instr_ready && !redirect_valid;

    assign target_sum = redirect_base + redirect_offset;
    assign target     = target_sum & ~XLEN'(3);

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path
        // through this block leaves a variable unassigned and infers a latch.
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (redirect_valid) begin
            // Everything still outstanding (minus the response consumed now) is stale.
            fetch_pc_d = target;
            rsp_pc_d   = target;
            inflight_d = inflight_q - CW'(imem_rsp_valid);
            drop_d     = inflight_q - CW'(imem_rsp_valid);
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);

            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end

            if (push) begin
                rsp_pc_d = rsp_pc_q + XLEN'(4);
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the storage is cleared on reset on purpose: the head outputs
        // (instr, instr_pc, instr_link) must read as defined values out of reset.
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]    <= '0;
                mem_instr_q[i] <= '0;
            end
        end else if (push) begin
            mem_pc_q[wr_ptr_q]    <= rsp_pc_q;
            mem_instr_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count_q == CW'(DEPTH))))
        else $error("fetch_unit_pf: prefetch fifo overflow");

    a_no_spurious_rsp : assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid && (inflight_q == '0)))
        else $error("fetch_unit_pf: response with nothing in flight");

endmodule

// File: tb/tb_fetch_unit_pf.sv
// Directed bench for fetch_unit_pf: a latency-L in-order memory model feeds the
// unit and a scoreboard checks every instruction decode accepts.
module tb_fetch_unit_pf;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] MAGIC = 32'hC0DE_0000;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_base;
    logic [31:0] redirect_offset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_link;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pops  = 0;
    int          lat     = 1;
    logic [31:0] exp_pc  = 32'h0;

    logic [31:0] pend_addr[$];
    int          pend_dly[$];

    fetch_unit_pf #(.XLEN(XLEN), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_base   (redirect_base),
        .redirect_offset (redirect_offset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_link      (instr_link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic mem_clear();
        pend_addr.delete();
        pend_dly.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
    endtask

    // One clock: sample the pre-edge handshakes, score any pop, advance the memory.
    task automatic step();
        logic        hs;
        logic [31:0] hs_addr;
        logic        rsp_now;
        #1;
        hs      = imem_req_valid && imem_req_ready;
        hs_addr = imem_req_addr;
        rsp_now = imem_rsp_valid;
        if (instr_valid && instr_ready && !redirect_valid && !reset) begin
            check("pop_pc", instr_pc, exp_pc);
            check("pop_instr", instr, exp_pc ^ MAGIC);
            check("pop_link", instr_link, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            n_pops++;
        end
        @(posedge clk);
        #1;
        if (rsp_now && pend_addr.size() > 0) begin
            void'(pend_addr.pop_front());
            void'(pend_dly.pop_front());
        end
        foreach (pend_dly[i]) begin
            if (pend_dly[i] > 0) pend_dly[i] = pend_dly[i] - 1;
        end
        if (hs) begin
            pend_addr.push_back(hs_addr);
            pend_dly.push_back(lat - 1);
        end
        if (pend_addr.size() > 0 && pend_dly[0] == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend_addr[0] ^ MAGIC;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic redirect(input logic [31:0] base, input logic [31:0] off);
        redirect_valid  = 1'b1;
        redirect_base   = base;
        redirect_offset = off;
        #1;
        check("redir_noreq", {31'h0, imem_req_valid}, 32'h0);
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_base   = 32'h0;
        redirect_offset = 32'h0;
        imem_req_ready  = 1'b1;
        instr_ready     = 1'b0;
        mem_clear();
        step();
        step();

        // Reset values
        check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("rst_req_addr", imem_req_addr, RPC);
        check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_instr_link", instr_link, 32'h4);

        // Sequential fetch, L=1
        reset       = 1'b0;
        instr_ready = 1'b1;
        exp_pc      = RPC;
        #1;
        check("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("first_req_addr", imem_req_addr, 32'h0);
        step();
        check("fill_c1", {31'h0, instr_valid}, 32'h0);
        step();
        check("fill_c2", {31'h0, instr_valid}, 32'h1);
        n_pops = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("stream_valid", {31'h0, instr_valid}, 32'h1);
        end
        check("seq_pops", 32'(n_pops), 32'd8);

        // Back-pressure: FIFO fills to DEPTH, requests stop
        instr_ready = 1'b0;
        repeat (10) step();
        check("bp_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("bp_instr_valid", {31'h0, instr_valid}, 32'h1);
        check("bp_head_pc", instr_pc, exp_pc);
        check("bp_fetch_pc", imem_req_addr, exp_pc + 32'd16);
        instr_ready = 1'b1;
        n_pops = 0;
        repeat (12) step();
        check("bp_release_pops", 32'(n_pops), 32'd12);

        // Redirect with two in flight, L=2
        reset = 1'b1;
        mem_clear();
        step();
        reset  = 1'b0;
        lat    = 2;
        exp_pc = RPC;
        step();
        step();
        redirect(32'h20, 32'h40);
        exp_pc = 32'h60;
        #1;
        check("redir_req_addr", imem_req_addr, 32'h60);
        check("redir_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("redir_drop", 32'(dut.drop_q), 32'h1);
        check("redir_gap_c3", {31'h0, instr_valid}, 32'h0);
        step();
        check("redir_gap_c4", {31'h0, instr_valid}, 32'h0);
        step();
        check("redir_gap_c5", {31'h0, instr_valid}, 32'h0);
        step();
        check("redir_first_valid", {31'h0, instr_valid}, 32'h1);
        check("redir_first_pc", instr_pc, 32'h60);
        step();
        check("redir_second_pc", instr_pc, 32'h64);

        // Negative offset and alignment
        redirect(32'h100, 32'hFFFF_FFF3);
        exp_pc = 32'hF0;
        #1;
        check("neg_target", imem_req_addr, 32'hF0);
        n_pops = 0;
        repeat (6) step();
        check("neg_pops", 32'(n_pops), 32'd3);

        // Redirect coinciding with a response and a pop, then a second redirect
        check("coinc_valid", {31'h0, instr_valid}, 32'h1);
        check("coinc_rsp", {31'h0, imem_rsp_valid}, 32'h1);
        redirect(32'h200, 32'h0);
        redirect(32'h300, 32'h10);
        exp_pc = 32'h310;
        #1;
        check("dbl_drop_zero", 32'(dut.drop_q), 32'h0);
        check("dbl_req_addr", imem_req_addr, 32'h310);
        n_pops = 0;
        repeat (6) step();
        check("dbl_pops", 32'(n_pops), 32'd3);

        // PC wrap at the top of the address space
        redirect(32'hFFFF_FFF8, 32'h0);
        exp_pc = 32'hFFFF_FFF8;
        n_pops = 0;
        repeat (7) step();
        check("wrap_pops", 32'(n_pops), 32'd4);
        check("wrap_head_pc", instr_pc, 32'h8);

        // Reset mid-stream with a full FIFO
        instr_ready = 1'b0;
        repeat (10) step();
        check("full_valid", {31'h0, instr_valid}, 32'h1);
        check("full_req_valid", {31'h0, imem_req_valid}, 32'h0);
        reset = 1'b1;
        mem_clear();
        step();
        check("midrst_instr_valid", {31'h0, instr_valid}, 32'h0);
        check("midrst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("midrst_req_addr", imem_req_addr, RPC);
        check("midrst_instr_pc", instr_pc, 32'h0);
        reset       = 1'b0;
        instr_ready = 1'b1;
        exp_pc      = RPC;
        #1;
        check("restart_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("restart_req_addr", imem_req_addr, RPC);
        n_pops = 0;
        repeat (8) step();
        check("restart_pops", 32'(n_pops), 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
